// File: rtl/hash_result_scanner_pkg.sv
// Shared types and constants for the hash result scanner: FSM encoding,
// summary word layout and the minimum-tracker seed value.
package hash_result_scanner_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_READ   = 3'd1;
  localparam state_t ST_WR_MIN = 3'd2;
  localparam state_t ST_WR_MAP = 3'd3;
  localparam state_t ST_FIN    = 3'd4;

  localparam logic [31:0] MIN_INIT = 32'hFFFF_FFFF;

  // Second summary word: hit bitmap in the top half, winning-min nonce at the bottom.
  typedef struct packed {
    logic [15:0] bitmap;
    logic [9:0]  rsvd;
    logic [5:0]  nonce;
  } summary_map_t;

endpackage

// File: rtl/hash_result_scanner_if.sv
// Single-port, word-addressed shared memory bus. The scanner drives the
// master side; the memory (or a model of it) sits on the slave side.
interface hash_result_scanner_if;

  logic        mem_clk;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  modport master (
    output mem_clk, mem_we, mem_addr, mem_write_data,
    input  mem_read_data
  );

  modport slave (
    input  mem_clk, mem_we, mem_addr, mem_write_data,
    output mem_read_data
  );

endinterface

// File: rtl/hash_result_scanner_result_cmp.sv
// Combinational unsigned compare of one result word against the difficulty
// target and against the running minimum.
module hash_result_scanner_result_cmp (
  input  logic [31:0] value,
  input  logic [31:0] target,
  input  logic [31:0] min_value,
  output logic        hit,
  output logic        new_min
);

  assign hit     = value < target;
  assign new_min = value < min_value;

endmodule

// File: rtl/hash_result_scanner.sv
// Streams NUM_NONCES result words through pipelined reads, finds the first
// word below target and the minimum word, then writes a two-word summary.
module hash_result_scanner
  import hash_result_scanner_pkg::*;
#(
  parameter int NUM_NONCES   = 16,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [15:0]           result_addr,
  input  logic [15:0]           summary_addr,
  input  logic [31:0]           target,
  output logic                  done,
  output logic                  found,
  output logic [5:0]            found_nonce,
  output logic [5:0]            min_nonce,
  output logic [31:0]           min_value,
  hash_result_scanner_if.master mem
);

  localparam int          IDX_W   = $clog2(NUM_NONCES);
  localparam int          LAT_W   = $clog2(READ_LATENCY + 1);
  localparam logic [5:0]  N_CNT   = 6'(NUM_NONCES);
  localparam logic [5:0]  LAST    = 6'(NUM_NONCES - 1);
  localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'(READ_LATENCY);

  state_t                  state;
  logic [31:0]             target_q;
  logic [15:0]             sum_addr_q;
  logic [5:0]              issue_cnt;
  logic [5:0]              recv_cnt;
  logic [LAT_W-1:0]        lat_cnt;
  logic [NUM_NONCES-1:0]   bitmap;
  logic [15:0]             map16;
  logic                    mem_we_q;
  logic [15:0]             mem_addr_q;
  logic [31:0]             mem_wdata_q;
  logic                    hit;
  logic                    new_min;
  logic [IDX_W-1:0]        recv_idx;
  summary_map_t            map_word;

  assign mem.mem_clk        = clk;
  assign mem.mem_we         = mem_we_q;
  assign mem.mem_addr       = mem_addr_q;
  assign mem.mem_write_data = mem_wdata_q;

  assign recv_idx = recv_cnt[IDX_W-1:0];

  hash_result_scanner_result_cmp u_cmp (
    .value     (mem.mem_read_data),
    .target    (target_q),
    .min_value (min_value),
    .hit       (hit),
    .new_min   (new_min)
  );

  generate
    if (NUM_NONCES >= 16) begin : g_map_trunc
      assign map16 = bitmap[15:0];
    end else begin : g_map_ext
      assign map16 = {{(16 - NUM_NONCES){1'b0}}, bitmap};
    end
  endgenerate

  assign map_word = '{bitmap: map16, rsvd: 10'd0, nonce: min_nonce};

  // NOTE: all state below is updated with non-blocking assignments so every
  // register sees the pre-edge value of every other register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      done        <= 1'b0;
      found       <= 1'b0;
      found_nonce <= '0;
      min_nonce   <= '0;
      min_value   <= MIN_INIT;
      target_q    <= '0;
      sum_addr_q  <= '0;
      issue_cnt   <= '0;
      recv_cnt    <= '0;
      lat_cnt     <= '0;
      bitmap      <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            target_q    <= target;
            sum_addr_q  <= summary_addr;
            found       <= 1'b0;
            found_nonce <= '0;
            min_nonce   <= '0;
            min_value   <= MIN_INIT;
            bitmap      <= '0;
            mem_addr_q  <= result_addr;
            mem_we_q    <= 1'b0;
            issue_cnt   <= 6'd1;
            recv_cnt    <= '0;
            lat_cnt     <= LAT_W'(1);
            state       <= ST_READ;
          end
        end

        ST_READ: begin
          if (issue_cnt < N_CNT) begin
            mem_addr_q <= mem_addr_q + 16'd1;
            issue_cnt  <= issue_cnt + 6'd1;
          end
          // Captures begin READ_LATENCY edges after the first address went out.
          if (lat_cnt < LAT_MAX) begin
            lat_cnt <= lat_cnt + LAT_W'(1);
          end else begin
            bitmap[recv_idx] <= hit;
            if (hit && !found) begin
              found       <= 1'b1;
              found_nonce <= recv_cnt;
            end
            if (new_min) begin
              min_value <= mem.mem_read_data;
              min_nonce <= recv_cnt;
            end
            recv_cnt <= recv_cnt + 6'd1;
            if (recv_cnt == LAST) state <= ST_WR_MIN;
          end
        end

        ST_WR_MIN: begin
          mem_we_q    <= 1'b1;
          mem_addr_q  <= sum_addr_q;
          mem_wdata_q <= min_value;
          state       <= ST_WR_MAP;
        end

        ST_WR_MAP: begin
          mem_addr_q  <= sum_addr_q + 16'd1;
          mem_wdata_q <= map_word;
          state       <= ST_FIN;
        end

        ST_FIN: begin
          mem_we_q <= 1'b0;
          done     <= 1'b1;
          state    <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
